rs232_tx: RTL and testbench

//   UART/RS-232 transmitter, companion to the project's 16x-oversampling receiver.

---
 rtl/rs232_tx.sv | 170 +++++++++++++++++
 tb/tb_rs232_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_tx.sv
// rtl/rs232_tx.sv - RS-232 transmitter: byte FIFO feeding an 8N1 serialiser
//
// Ports:
//   clk         - single clock, all logic on posedge
//   rst_n       - synchronous active-low reset
//   data_in     - byte to transmit
//   data_valid  - source offers data_in this cycle
//   data_ready  - FIFO has room (decoded from registered fifo_count only)
//   signal_out  - registered serial line, idles high
//   busy        - registered: frame in flight or bytes queued
//   fifo_count  - bytes queued, excluding the frame in flight
module rs232_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [7:0]                       data_in,
    input  logic                             data_valid,
    output logic                             data_ready,
    output logic                             signal_out,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] CYC_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] COUNT_FULL = NW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [NW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          bit_end;
    logic          fifo_empty;

    assign data_ready = (fifo_count != COUNT_FULL);
    assign push       = data_valid & data_ready;
    assign fifo_empty = (fifo_count == '0);
    assign bit_end    = (cyc_cnt == CYC_LAST);

    // Pops happen only on entry to START, either from IDLE or straight out
    // of the last STOP cycle so back-to-back frames have no idle gap.
    always_comb begin
        pop        = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end && bit_cnt == 3'd7) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = fifo_count;
        if (push && !pop)      count_next = fifo_count + NW'(1);
        else if (pop && !push) count_next = fifo_count - NW'(1);
    end

    // Storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            signal_out <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            fifo_count <= count_next;
            busy       <= (state_next != IDLE) | (count_next != '0);

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                shift  <= fifo_mem[rd_ptr];
            end

            case (state)
                IDLE: begin
                    cyc_cnt    <= '0;
                    bit_cnt    <= '0;
                    signal_out <= !pop;
                end
                START: begin
                    if (bit_end) begin
                        cyc_cnt    <= '0;
                        bit_cnt    <= '0;
                        signal_out <= shift[0];
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            signal_out <= 1'b1;
                        end else begin
                            // shift[0] is on the line; present the next bit.
                            bit_cnt    <= bit_cnt + 3'd1;
                            signal_out <= shift[1];
                            shift      <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cyc_cnt    <= '0;
                        bit_cnt    <= '0;
                        signal_out <= !pop;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                default: begin
                    cyc_cnt    <= '0;
                    bit_cnt    <= '0;
                    signal_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_tx.sv
// tb/tb_rs232_tx.sv - scoreboard bench for rs232_tx
module tb_rs232_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       signal_out;
    logic       busy;
    logic [2:0] fifo_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] exp_q [$];
    int         frame_starts [$];

    rs232_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .signal_out (signal_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: decodes each frame from 160 line samples, requiring every
    // bit to be stable for its full 16 cycles, then scores against exp_q.
    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    logic       glitch = 1'b0;
    logic [9:0] bits = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && signal_out == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                glitch     = 1'b0;
                frame_starts.push_back(cyc);
            end
            if (mon_active) begin
                if (mon_cnt % 16 == 0) bits[mon_cnt / 16] = signal_out;
                else if (signal_out !== bits[mon_cnt / 16]) glitch = 1'b1;
                mon_cnt++;
                if (mon_cnt == 160) begin
                    mon_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {24'h0, bits[8:1]}, 32'hFFFF_FFFF);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("frame_byte",
                              {23'h0, (bits[0] == 1'b0 && bits[9] == 1'b1 && !glitch), bits[8:1]},
                              {23'h0, 1'b1, e});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit, output int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < limit);
        check("idle_within_bound", 32'(busy), 32'h0);
        t = cyc;
    endtask

    initial begin
        int s0;
        int t_idle;
        int lows;
        logic [7:0] b4 [6];

        // 1: reset
        rst_n = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("rst_signal_out", 32'(signal_out), 32'h1);
        check("rst_data_ready", 32'(data_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fifo_count", 32'(fifo_count), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // 2: single byte 0xA5, one-edge latency, 160-cycle frame
        s0 = frame_starts.size();
        data_valid = 1'b1; data_in = 8'hA5; exp_q.push_back(8'hA5);
        tick();
        data_valid = 1'b0;
        @(negedge clk);
        check("lat_line_still_high", 32'(signal_out), 32'h1);
        check("lat_count_1", 32'(fifo_count), 32'h1);
        check("lat_busy", 32'(busy), 32'h1);
        tick();
        @(negedge clk);
        check("lat_line_falls", 32'(signal_out), 32'h0);
        check("lat_count_0", 32'(fifo_count), 32'h0);
        wait_idle(400, t_idle);
        check("a5_frames", 32'(frame_starts.size() - s0), 32'd1);
        if (frame_starts.size() > s0)
            check("a5_busy_len", 32'(t_idle - frame_starts[s0]), 32'd160);
        check("a5_line_idle", 32'(signal_out), 32'h1);

        // 3: three back-to-back bytes
        tick();
        s0 = frame_starts.size();
        data_valid = 1'b1;
        data_in = 8'h00; exp_q.push_back(8'h00); tick();
        data_in = 8'hFF; exp_q.push_back(8'hFF); tick();
        data_in = 8'h55; exp_q.push_back(8'h55); tick();
        data_valid = 1'b0;
        wait_idle(1000, t_idle);
        check("b2b_frames", 32'(frame_starts.size() - s0), 32'd3);
        if (frame_starts.size() >= s0 + 3) begin
            check("b2b_gap_1", 32'(frame_starts[s0+1] - frame_starts[s0]), 32'd160);
            check("b2b_gap_2", 32'(frame_starts[s0+2] - frame_starts[s0+1]), 32'd160);
            check("b2b_total", 32'(t_idle - frame_starts[s0]), 32'd480);
        end

        // 4: hold data_valid, fill FIFO, backpressure
        tick();
        b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h3C;
        b4[3] = 8'h81; b4[4] = 8'h7E; b4[5] = 8'hC3;
        for (int i = 0; i < 6; i++) exp_q.push_back(b4[i]);
        data_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = b4[i];
            tick();
        end
        data_in = b4[5];
        @(negedge clk);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_ready", 32'(data_ready), 32'h0);
        repeat (157) tick();
        @(negedge clk);
        check("reopen_count", 32'(fifo_count), 32'd3);
        check("reopen_ready", 32'(data_ready), 32'h1);
        tick();
        data_valid = 1'b0;
        @(negedge clk);
        check("refill_count", 32'(fifo_count), 32'd4);
        check("refill_ready", 32'(data_ready), 32'h0);
        wait_idle(2000, t_idle);

        // 5: reset mid-frame with two bytes queued
        tick();
        data_valid = 1'b1;
        data_in = 8'hE1; tick();
        data_in = 8'hE2; tick();
        data_in = 8'hE3; tick();
        data_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_count", 32'(fifo_count), 32'd2);
        repeat (68) tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("mid_rst_line", 32'(signal_out), 32'h1);
        check("mid_rst_count", 32'(fifo_count), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_ready", 32'(data_ready), 32'h1);
        tick();
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (signal_out == 1'b0) lows++;
        end
        check("post_rst_silent", 32'(lows), 32'd0);

        // 6: push on the last STOP cycle with one byte queued
        tick();
        s0 = frame_starts.size();
        data_valid = 1'b1; data_in = 8'h96; exp_q.push_back(8'h96);
        tick();
        data_valid = 1'b0;
        repeat (4) tick();
        data_valid = 1'b1; data_in = 8'h3A; exp_q.push_back(8'h3A);
        tick();
        data_valid = 1'b0;
        repeat (155) tick();
        data_valid = 1'b1; data_in = 8'hD2; exp_q.push_back(8'hD2);
        @(negedge clk);
        check("last_stop_count", 32'(fifo_count), 32'd1);
        check("last_stop_line", 32'(signal_out), 32'h1);
        tick();
        data_valid = 1'b0;
        @(negedge clk);
        check("pushpop_count", 32'(fifo_count), 32'd1);
        check("pushpop_line", 32'(signal_out), 32'h0);
        wait_idle(1000, t_idle);
        check("pp_frames", 32'(frame_starts.size() - s0), 32'd3);
        if (frame_starts.size() >= s0 + 3) begin
            check("pp_gap_1", 32'(frame_starts[s0+1] - frame_starts[s0]), 32'd160);
            check("pp_gap_2", 32'(frame_starts[s0+2] - frame_starts[s0+1]), 32'd160);
        end

        repeat (5) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
